mcb_port_responder: RTL

Synthesizable responder model of one Spartan-6 MCB user port (cmd/wr/rd FIFO triplet) backed by an on-chip RAM. It stands in for the memory controller so DDR test masters and other port initiators can be simulated and run on-chip without external DRAM. The block emulates calibration, accepts commands through a 4-deep command FIFO, and drains or fills 64-deep write and read data FIFOs with MCB-like flag behaviour.

---
 rtl/mcb_pkg.sv | 36 +++
 rtl/sync_fifo.sv | 75 +++++++
 rtl/mcb_port_responder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mcb_pkg.sv
// Shared definitions for the MCB user-port responder: instruction codes,
// engine states, command layout and FIFO geometry.
package mcb_pkg;

  localparam logic [2:0] INSTR_WRITE    = 3'b000;
  localparam logic [2:0] INSTR_READ     = 3'b001;
  localparam logic [2:0] INSTR_WRITE_AP = 3'b010;
  localparam logic [2:0] INSTR_READ_AP  = 3'b011;
  localparam logic [2:0] INSTR_REFRESH  = 3'b100;

  localparam int CMD_DEPTH   = 4;
  localparam int DATA_DEPTH  = 64;
  localparam int COUNT_WIDTH = 7;
  localparam int WR_WIDTH    = 36;
  localparam int RD_WIDTH    = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WRITE,
    ST_READ_WAIT,
    ST_READ,
    ST_REFRESH
  } engine_state_t;

  // Command FIFO entry; the two spare bits keep the entry at 41 bits.
  typedef struct packed {
    logic [1:0]  spare;
    logic [2:0]  instr;
    logic [5:0]  bl;
    logic [29:0] byte_addr;
  } cmd_t;

  localparam int CMD_WIDTH = $bits(cmd_t);

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered count/full/empty.
// A push on a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 64,
  parameter int COUNT_WIDTH = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [WIDTH-1:0]       mem [0:DEPTH-1];
  logic [PTR_WIDTH-1:0]   wr_ptr_reg;
  logic [PTR_WIDTH-1:0]   rd_ptr_reg;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic [COUNT_WIDTH-1:0] count_next;
  logic                   full_reg;
  logic                   empty_reg;
  logic                   do_push;
  logic                   do_pop;

  assign do_pop  = pop && !empty_reg;
  assign do_push = push && (!full_reg || pop);

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + 1'b1;
    end else if (do_pop && !do_push) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
      full_reg  <= (count_next == COUNT_WIDTH'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Head word is forced to zero while empty so the output is defined from reset.
  assign dout  = empty_reg ? '0 : mem[rd_ptr_reg];
  assign full  = full_reg;
  assign empty = empty_reg;
  assign count = count_reg;

endmodule

// File: rtl/mcb_port_responder.sv
// Spartan-6 MCB user-port stand-in: calibration delay, command/write/read FIFOs
// and a single burst engine serving a byte-masked on-chip RAM.
module mcb_port_responder
  import mcb_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int CALIB_CYCLES   = 16,
  parameter int READ_LATENCY   = 8,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        calib_done,
  input  logic        cmd_en,
  input  logic [2:0]  cmd_instr,
  input  logic [5:0]  cmd_bl,
  input  logic [29:0] cmd_byte_addr,
  output logic        cmd_empty,
  output logic        cmd_full,
  input  logic        wr_en,
  input  logic [3:0]  wr_mask,
  input  logic [31:0] wr_data,
  output logic        wr_full,
  output logic        wr_empty,
  output logic [6:0]  wr_count,
  output logic        wr_underrun,
  output logic        wr_error,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        rd_full,
  output logic        rd_empty,
  output logic [6:0]  rd_count,
  output logic        rd_overflow,
  output logic        rd_error
);

  localparam int MEM_WORDS = 1 << MEM_ADDR_WIDTH;
  localparam int CAL_W     = $clog2(CALIB_CYCLES + 1);

  logic [CAL_W-1:0]          cal_cnt_reg;
  logic                      calib_done_reg;
  engine_state_t             state_reg;
  cmd_t                      cmd_reg;
  cmd_t                      cmd_in;
  cmd_t                      cmd_head;
  logic [MEM_ADDR_WIDTH-1:0] addr_reg;
  logic [5:0]                beat_reg;
  logic [7:0]                timer_reg;
  logic                      rd_push_reg;
  logic                      wr_underrun_reg;
  logic                      wr_error_reg;
  logic                      rd_overflow_reg;
  logic                      rd_error_reg;

  logic                      cmd_fifo_full;
  logic                      cmd_push;
  logic                      cmd_pop;
  logic [COUNT_WIDTH-1:0]    cmd_count;
  logic [WR_WIDTH-1:0]       wr_head;
  logic                      wr_pop;
  logic                      wr_drop;
  logic                      ram_we;
  logic [31:0]               ram_q;
  logic                      unused_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cal_cnt_reg    <= '0;
      calib_done_reg <= 1'b0;
    end else if (!calib_done_reg) begin
      cal_cnt_reg <= cal_cnt_reg + 1'b1;
      if (cal_cnt_reg == CAL_W'(CALIB_CYCLES - 1)) begin
        calib_done_reg <= 1'b1;
      end
    end
  end

  // The port looks full until calibration completes, so early commands are dropped.
  assign cmd_full = !calib_done_reg || cmd_fifo_full;
  assign cmd_push = cmd_en && !cmd_full;
  assign cmd_pop  = (state_reg == ST_IDLE) && !cmd_empty;
  assign cmd_in   = {2'b00, cmd_instr, cmd_bl, cmd_byte_addr};

  sync_fifo #(.WIDTH(CMD_WIDTH), .DEPTH(CMD_DEPTH), .COUNT_WIDTH(COUNT_WIDTH)) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_push),
    .din   (cmd_in),
    .pop   (cmd_pop),
    .dout  (cmd_head),
    .full  (cmd_fifo_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  assign wr_pop  = (state_reg == ST_WRITE);
  assign wr_drop = wr_en && wr_full && !wr_pop;
  assign ram_we  = wr_pop && !wr_empty;

  sync_fifo #(.WIDTH(WR_WIDTH), .DEPTH(DATA_DEPTH), .COUNT_WIDTH(COUNT_WIDTH)) u_wr_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_en),
    .din   ({wr_mask, wr_data}),
    .pop   (wr_pop),
    .dout  (wr_head),
    .full  (wr_full),
    .empty (wr_empty),
    .count (wr_count)
  );

  sync_fifo #(.WIDTH(RD_WIDTH), .DEPTH(DATA_DEPTH), .COUNT_WIDTH(COUNT_WIDTH)) u_rd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_push_reg),
    .din   (ram_q),
    .pop   (rd_en),
    .dout  (rd_data),
    .full  (rd_full),
    .empty (rd_empty),
    .count (rd_count)
  );

  // One RAM per byte lane gives per-byte write enables with a registered read port.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [0:MEM_WORDS-1];
      logic [7:0] lane_q;
      always_ff @(posedge clk) begin
        if (ram_we && !wr_head[32+gi]) begin
          lane_mem[addr_reg] <= wr_head[gi*8 +: 8];
        end
        lane_q <= lane_mem[addr_reg];
      end
      assign ram_q[gi*8 +: 8] = lane_q;
    end
  endgenerate

  // READ_WAIT is one cycle short of READ_LATENCY because the RAM read adds a stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cmd_reg     <= '0;
      addr_reg    <= '0;
      beat_reg    <= '0;
      timer_reg   <= '0;
      rd_push_reg <= 1'b0;
    end else begin
      rd_push_reg <= (state_reg == ST_READ);
      case (state_reg)
        ST_IDLE: begin
          if (!cmd_empty) begin
            cmd_reg   <= cmd_head;
            state_reg <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          addr_reg <= cmd_reg.byte_addr[MEM_ADDR_WIDTH+1:2];
          beat_reg <= cmd_reg.bl;
          case (cmd_reg.instr)
            INSTR_WRITE, INSTR_WRITE_AP: state_reg <= ST_WRITE;
            INSTR_READ, INSTR_READ_AP: begin
              timer_reg <= 8'(READ_LATENCY - 2);
              state_reg <= ST_READ_WAIT;
            end
            INSTR_REFRESH: begin
              timer_reg <= 8'(REFRESH_CYCLES - 1);
              state_reg <= ST_REFRESH;
            end
            default: state_reg <= ST_IDLE;
          endcase
        end
        ST_WRITE, ST_READ: begin
          addr_reg <= addr_reg + 1'b1;
          if (beat_reg == 6'd0) begin
            state_reg <= ST_IDLE;
          end else begin
            beat_reg <= beat_reg - 1'b1;
          end
        end
        ST_READ_WAIT: begin
          if (timer_reg == 8'd0) begin
            state_reg <= ST_READ;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        ST_REFRESH: begin
          if (timer_reg == 8'd0) begin
            state_reg <= ST_IDLE;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_underrun_reg <= 1'b0;
      wr_error_reg    <= 1'b0;
      rd_overflow_reg <= 1'b0;
      rd_error_reg    <= 1'b0;
    end else begin
      wr_underrun_reg <= wr_pop && wr_empty;
      rd_overflow_reg <= rd_push_reg && rd_full && !rd_en;
      if ((wr_pop && wr_empty) || wr_drop) begin
        wr_error_reg <= 1'b1;
      end
      if ((rd_push_reg && rd_full && !rd_en) || (rd_en && rd_empty)) begin
        rd_error_reg <= 1'b1;
      end
    end
  end

  assign calib_done  = calib_done_reg;
  assign wr_underrun = wr_underrun_reg;
  assign wr_error    = wr_error_reg;
  assign rd_overflow = rd_overflow_reg;
  assign rd_error    = rd_error_reg;
  assign unused_bits = ^{cmd_reg.spare, cmd_reg.byte_addr, cmd_count};

endmodule
